// File: rtl/ram_64_loader.sv
`default_nettype none
// ============================================================================
//  Module      : ram_64_loader
//  Description : Burst sequencer that sits directly upstream of a ram_64.
//                Accepts words over a valid/ready stream and writes them to
//                consecutive RAM addresses starting at a programmable base.
//                Addresses wrap modulo the RAM depth. The burst length is
//                clamped to the depth.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          system clock, rising-edge active
//    reset          asynchronous, active-high reset
//    start          one-cycle burst request, sampled only while idle
//    base_addr      first RAM address of the burst (captured on start)
//    count          burst length 0..127 (captured on start, clamped to 64)
//    in_data        stream data word
//    in_valid       stream word present
//    in_ready       loader can accept a word this cycle
//    ram_in         ram_64 data input
//    ram_addr       ram_64 address
//    ram_load       ram_64 write enable
//    busy           high in every state except IDLE
//    done           one-cycle pulse when a burst completes
//    words_written  words written in the current or last burst
//  Optional feature (macro RAM64_LOADER_VERIFY_EN)
//    ram_out        ram_64 data output, read back after the burst
//    verify_err     set at completion when the read-back sum differs from the
//                   sum of the accepted words; held until the next start
// ============================================================================
module ram_64_loader #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [6:0]        count,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    output logic              busy,
    output logic              done,
    output logic [6:0]        words_written
`ifdef RAM64_LOADER_VERIFY_EN
    ,
    input  logic [WORD_W-1:0] ram_out,
    output logic              verify_err
`endif
);

    localparam int c_depth = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DONE   = 2'd2,
        S_VERIFY = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [6:0]        r_remaining;

    logic              w_accept;
    logic [6:0]        w_count_clamped;

`ifdef RAM64_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] r_base;
    logic [6:0]        r_total;
    logic [WORD_W-1:0] r_sum_wr;
    logic [WORD_W-1:0] r_sum_rd;
    logic [WORD_W-1:0] w_sum_rd_next;

    assign w_sum_rd_next = r_sum_rd + ram_out;
`endif

    // Requests longer than the RAM would overwrite their own first words.
    assign w_count_clamped = (count > 7'(c_depth)) ? 7'(c_depth) : count;

    // in_ready is only ever high in LOAD, so it alone qualifies the accept.
    assign w_accept = in_ready && in_valid;

    // Zero-latency write path: the RAM captures the word on the accept edge.
    assign ram_load = w_accept;
    assign ram_in   = in_data;
    assign ram_addr = r_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_remaining   <= '0;
            in_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
`ifdef RAM64_LOADER_VERIFY_EN
            r_base        <= '0;
            r_total       <= '0;
            r_sum_wr      <= '0;
            r_sum_rd      <= '0;
            verify_err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr        <= base_addr;
                        r_remaining   <= w_count_clamped;
                        words_written <= '0;
                        busy          <= 1'b1;
`ifdef RAM64_LOADER_VERIFY_EN
                        r_base        <= base_addr;
                        r_total       <= w_count_clamped;
                        r_sum_wr      <= '0;
                        r_sum_rd      <= '0;
                        verify_err    <= 1'b0;
`endif
                        if (w_count_clamped == 7'd0) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state  <= S_LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        r_addr        <= r_addr + 1'b1;
                        r_remaining   <= r_remaining - 7'd1;
                        words_written <= words_written + 7'd1;
`ifdef RAM64_LOADER_VERIFY_EN
                        r_sum_wr      <= r_sum_wr + in_data;
`endif
                        // Last word: drop in_ready now so nothing past the
                        // burst length can be accepted.
                        if (r_remaining == 7'd1) begin
                            in_ready <= 1'b0;
`ifdef RAM64_LOADER_VERIFY_EN
                            // Rewind the address for the read-back pass.
                            r_state     <= S_VERIFY;
                            r_addr      <= r_base;
                            r_remaining <= r_total;
`else
                            r_state     <= S_DONE;
                            done        <= 1'b1;
`endif
                        end
                    end
                end

`ifdef RAM64_LOADER_VERIFY_EN
                S_VERIFY: begin
                    r_sum_rd    <= w_sum_rd_next;
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 7'd1;
                    if (r_remaining == 7'd1) begin
                        r_state    <= S_DONE;
                        done       <= 1'b1;
                        verify_err <= (w_sum_rd_next != r_sum_wr);
                    end
                end
`endif

                S_DONE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state  <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_64_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_64_loader
//  Description : Self-checking bench for ram_64_loader. A behavioural RAM
//                sits behind the loader; an expected-memory image and the
//                expected write sequence are computed from the burst rules
//                (base + i mod 64, length clamped to 64).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_64_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [6:0]  count = '0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ram_in;
    logic [5:0]  ram_addr;
    logic        ram_load;
    logic        busy;
    logic        done;
    logic [6:0]  words_written;

    logic [15:0] mem      [64];
    logic [15:0] exp_mem  [64];
    logic [15:0] fill_vals[64];
    logic        fill_mem = 1'b1;

`ifdef RAM64_LOADER_VERIFY_EN
    localparam bit VERIFY_MODE = 1'b1;
    logic [15:0] ram_out;
    logic        verify_err;
    int          corrupt_addr = -1;
    assign ram_out = mem[ram_addr] ^ ((int'(ram_addr) == corrupt_addr) ? 16'h0100 : 16'h0000);
`else
    localparam bit VERIFY_MODE = 1'b0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Write log and protocol monitor
    logic [5:0]  wlog_a[$];
    logic [15:0] wlog_d[$];
    int          log_start = 0;
    int          viol = 0;
    logic        pend_w = 1'b0;
    logic [5:0]  pend_a = '0;
    logic [15:0] pend_d = '0;

    // Burst driver results
    logic [15:0] stim_q[$];
    int          acc_n, lat, ww_done, err_done;

    ram_64_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ram_in       (ram_in),
        .ram_addr     (ram_addr),
        .ram_load     (ram_load),
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
`ifdef RAM64_LOADER_VERIFY_EN
        ,
        .ram_out      (ram_out),
        .verify_err   (verify_err)
`endif
    );

    always #5 clock = ~clock;

    // Sample the write port mid-cycle; commit on the following rising edge.
    always @(negedge clock) begin
        pend_w = (ram_load === 1'b1);
        pend_a = ram_addr;
        pend_d = ram_in;
        if (pend_w) begin
            wlog_a.push_back(ram_addr);
            wlog_d.push_back(ram_in);
        end
        if (ram_load === 1'b1 && (in_valid !== 1'b1 || busy !== 1'b1)) viol++;
    end

    always @(posedge clock) begin
        if (fill_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= fill_vals[i];
        end else if (pend_w) begin
            mem[pend_a] <= pend_d;
        end
    end

    // ---------------- reference model ----------------
    function automatic int clamp_n(input int c);
        return (c > 64) ? 64 : c;
    endfunction

    function automatic int exp_lat(input int c);
        return VERIFY_MODE ? 2 * clamp_n(c) : clamp_n(c);
    endfunction

    task automatic model_burst(input int b, input int n);
        for (int i = 0; i < n; i++) exp_mem[(b + i) % 64] = stim_q[i];
    endtask

    function automatic int mem_diffs();
        int d;
        d = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) d++;
        return d;
    endfunction

    function automatic int log_diffs(input int b, input int n);
        int d;
        d = 0;
        if (wlog_a.size() - log_start != n) return 1000;
        for (int i = 0; i < n; i++) begin
            if (wlog_a[log_start + i] !== 6'((b + i) % 64)) d++;
            if (wlog_d[log_start + i] !== stim_q[i]) d++;
        end
        return d;
    endfunction

    // ---------------- stimulus driver ----------------
    // Starts a burst, offers stim_q with random stalls, stops one cycle after done.
    task automatic run_burst(input int b, input int c, input int stall_pct, input int restart_at);
        int idx;
        log_start = wlog_a.size();
        lat = -1; ww_done = -1; err_done = 0; idx = 0;
        start = 1'b1; base_addr = 6'(b); count = 7'(c);
        @(posedge clock); #1;
        start = 1'b0; base_addr = 6'($urandom); count = 7'($urandom);
        for (int it = 0; it < 400 && lat < 0; it++) begin
            start    = (it == restart_at);
            in_valid = (idx < stim_q.size()) && ($urandom_range(0, 99) >= stall_pct);
            in_data  = in_valid ? stim_q[idx] : 16'($urandom);
            @(negedge clock);
            if (in_valid && in_ready === 1'b1) idx++;
            if (done === 1'b1) begin
                lat = it;
                ww_done = int'(words_written);
`ifdef RAM64_LOADER_VERIFY_EN
                err_done = int'(verify_err);
`endif
            end
            @(posedge clock); #1;
        end
        start = 1'b0; in_valid = 1'b0;
        acc_n = idx;
    endtask

    task automatic fill_stim(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(16'($urandom));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 64; i++) begin
            fill_vals[i] = 16'($urandom);
            exp_mem[i]   = fill_vals[i];
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if ({in_ready, ram_load, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 0000", {in_ready, ram_load, busy, done});
        end
        tests_run++;
        if (ram_addr !== 6'd0 || words_written !== 7'd0) begin
            tests_failed++;
            $display("FAIL reset_regs: got addr=%0d ww=%0d, expected 0/0", ram_addr, words_written);
        end
        @(posedge clock); #1;
        fill_mem = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        stim_q.delete();
        for (int i = 1; i <= 4; i++) stim_q.push_back(16'(i));
        run_burst(0, 4, 0, -1);
        model_burst(0, 4);
        tests_run++;
        if (lat !== exp_lat(4)) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d, expected %0d", lat, exp_lat(4));
        end
        tests_run++;
        if (log_diffs(0, 4) != 0) begin
            tests_failed++;
            $display("FAIL basic_writes: got %0d diffs, expected 0", log_diffs(0, 4));
        end
        tests_run++;
        if (ww_done !== 4) begin
            tests_failed++;
            $display("FAIL basic_words_written: got %0d, expected 4", ww_done);
        end
        @(negedge clock);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done_pulse: got done=%b busy=%b, expected 0/0", done, busy);
        end
        tests_run++;
        if (mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL basic_ram: got %0d bad addresses, expected 0", mem_diffs());
        end
        @(posedge clock); #1;
    endtask

    task automatic test_wrap();
        stim_q.delete();
        for (int i = 0; i < 4; i++) stim_q.push_back(16'(16'hA0 + i));
        run_burst(62, 4, 0, -1);
        model_burst(62, 4);
        tests_run++;
        if (log_diffs(62, 4) != 0) begin
            tests_failed++;
            $display("FAIL wrap_writes: got %0d diffs, expected 0", log_diffs(62, 4));
        end
        tests_run++;
        if (mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL wrap_ram: got %0d bad addresses, expected 0", mem_diffs());
        end
    endtask

    task automatic test_clamp();
        int b;
        b = $urandom_range(0, 63);
        fill_stim(100);
        run_burst(b, 100, 30, -1);
        model_burst(b, 64);
        tests_run++;
        if (acc_n !== 64 || ww_done !== 64) begin
            tests_failed++;
            $display("FAIL clamp_count: got accepted=%0d ww=%0d, expected 64/64", acc_n, ww_done);
        end
        tests_run++;
        if (log_diffs(b, 64) != 0 || mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL clamp_writes: got %0d/%0d diffs, expected 0/0", log_diffs(b, 64), mem_diffs());
        end
    endtask

    task automatic test_stalls();
        for (int k = 0; k < 6; k++) begin
            int b, c;
            b = $urandom_range(0, 63);
            c = $urandom_range(1, 127);
            fill_stim(clamp_n(c));
            run_burst(b, c, 40, -1);
            model_burst(b, clamp_n(c));
            tests_run++;
            if (lat < 0 || acc_n !== clamp_n(c) || ww_done !== clamp_n(c)) begin
                tests_failed++;
                $display("FAIL stall_burst%0d: got lat=%0d acc=%0d ww=%0d, expected done with %0d words",
                         k, lat, acc_n, ww_done, clamp_n(c));
            end
            tests_run++;
            if (log_diffs(b, clamp_n(c)) != 0 || mem_diffs() != 0) begin
                tests_failed++;
                $display("FAIL stall_writes%0d: got %0d/%0d diffs, expected 0/0",
                         k, log_diffs(b, clamp_n(c)), mem_diffs());
            end
        end
    endtask

    task automatic test_count_zero();
        fill_stim(3);
        run_burst(5, 0, 0, -1);
        tests_run++;
        if (lat !== 0 || acc_n !== 0 || ww_done !== 0) begin
            tests_failed++;
            $display("FAIL zero_count: got lat=%0d acc=%0d ww=%0d, expected 0/0/0", lat, acc_n, ww_done);
        end
        tests_run++;
        if (log_diffs(5, 0) != 0 || mem_diffs() != 0 || err_done !== 0) begin
            tests_failed++;
            $display("FAIL zero_writes: got %0d writes err=%0d, expected 0/0", wlog_a.size() - log_start, err_done);
        end
    endtask

    task automatic test_start_ignored();
        int b;
        b = $urandom_range(0, 63);
        fill_stim(6);
        run_burst(b, 6, 0, 2);
        model_burst(b, 6);
        tests_run++;
        if (lat !== exp_lat(6) || ww_done !== 6) begin
            tests_failed++;
            $display("FAIL restart_len: got lat=%0d ww=%0d, expected %0d/6", lat, ww_done, exp_lat(6));
        end
        tests_run++;
        if (log_diffs(b, 6) != 0 || mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL restart_writes: got %0d/%0d diffs, expected 0/0", log_diffs(b, 6), mem_diffs());
        end
    endtask

    task automatic test_reset_mid();
        int b;
        b = $urandom_range(20, 50);
        fill_stim(8);
        start = 1'b1; base_addr = 6'(b); count = 7'd8;
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = stim_q[k];
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (words_written !== 7'd3 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_before: got ww=%0d busy=%b, expected 3/1", words_written, busy);
        end
        #1 reset = 1'b1;
        #1;
        tests_run++;
        if ({in_ready, ram_load, busy, done} !== 4'b0000 || ram_addr !== 6'd0 || words_written !== 7'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got flags=%b addr=%0d ww=%0d, expected 0000/0/0",
                     {in_ready, ram_load, busy, done}, ram_addr, words_written);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        model_burst(b, 3);
        tests_run++;
        if (mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL midreset_ram: got %0d bad addresses, expected 0", mem_diffs());
        end
        fill_stim(2);
        run_burst(10, 2, 0, -1);
        model_burst(10, 2);
        tests_run++;
        if (lat !== exp_lat(2) || log_diffs(10, 2) != 0 || mem_diffs() != 0) begin
            tests_failed++;
            $display("FAIL midreset_after: got lat=%0d diffs=%0d/%0d, expected %0d/0/0",
                     lat, log_diffs(10, 2), mem_diffs(), exp_lat(2));
        end
    endtask

`ifdef RAM64_LOADER_VERIFY_EN
    task automatic test_verify();
        int b;
        b = $urandom_range(0, 63);
        fill_stim(5);
        run_burst(b, 5, 0, -1);
        model_burst(b, 5);
        tests_run++;
        if (lat !== exp_lat(5) || err_done !== 0) begin
            tests_failed++;
            $display("FAIL verify_clean: got lat=%0d err=%0d, expected %0d/0", lat, err_done, exp_lat(5));
        end
        corrupt_addr = (b + 2) % 64;
        run_burst(b, 5, 0, -1);
        tests_run++;
        if (err_done !== 1) begin
            tests_failed++;
            $display("FAIL verify_corrupt: got err=%0d, expected 1", err_done);
        end
        corrupt_addr = -1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++;
        if (verify_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL verify_hold: got %b, expected 1", verify_err);
        end
        @(posedge clock); #1;
        run_burst(b, 5, 0, -1);
        tests_run++;
        if (err_done !== 0) begin
            tests_failed++;
            $display("FAIL verify_clear: got err=%0d, expected 0", err_done);
        end
    endtask
`endif

    task automatic test_protocol();
        tests_run++;
        if (viol !== 0) begin
            tests_failed++;
            $display("FAIL ram_load_protocol: got %0d bad cycles, expected 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_clamp();
        test_stalls();
        test_count_zero();
        test_start_ignored();
        test_reset_mid();
`ifdef RAM64_LOADER_VERIFY_EN
        test_verify();
`endif
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
